// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command-bus decoder with per-bank open/row tracking and tRCD/tRP checks.
// All command and error outputs are registered one cycle after the sampling edge.
module ddr4_cmd_decoder #(
  parameter int TRCD = 4,
  parameter int TRP  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        cke,
  input  logic        act_n,
  input  logic        ras_n_a16,
  input  logic        cas_n_a15,
  input  logic        we_n_a14,
  input  logic        addr_17,
  input  logic [1:0]  bg,
  input  logic [1:0]  ba,
  input  logic [13:0] addr,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic [3:0]  cmd_bank,
  output logic [17:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        cmd_ap,
  output logic [15:0] bank_open,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [15:0] err_count
);

  typedef enum logic [3:0] {
    CMD_ACT  = 4'd0,
    CMD_RD   = 4'd1,
    CMD_WR   = 4'd2,
    CMD_PRE  = 4'd3,
    CMD_PREA = 4'd4,
    CMD_REF  = 4'd5,
    CMD_MRS  = 4'd6,
    CMD_ZQC  = 4'd7,
    CMD_RFU  = 4'd8
  } cmd_e;

  // Counters are armed with distance-1 so that zero means "timing-legal now".
  localparam logic [3:0] TRCD_ARM = 4'(TRCD - 1);
  localparam logic [3:0] TRP_ARM  = 4'(TRP - 1);

  logic [17:0] open_row [16];
  logic [3:0]  trcd_cnt [16];
  logic [3:0]  trp_cnt  [16];

  logic        dec_valid;
  cmd_e        dec_code;
  logic [3:0]  bank_idx;
  logic [17:0] act_row;
  logic        is_act, is_rdwr, is_pre, is_prea, is_ref, is_rfu, ap_bit;
  logic [15:0] act_hit, close_hit;
  logic [2:0]  err_now;

  assign bank_idx = {bg, ba};
  assign act_row  = {addr_17, ras_n_a16, cas_n_a15, we_n_a14, addr};
  assign ap_bit   = addr[10];

  always_comb begin
    dec_valid = 1'b0;
    dec_code  = CMD_ACT;
    if (cke && !cs_n) begin
      dec_valid = 1'b1;
      if (!act_n) begin
        dec_code = CMD_ACT;
      end else begin
        case ({ras_n_a16, cas_n_a15, we_n_a14})
          3'b000:  dec_code = CMD_MRS;
          3'b001:  dec_code = CMD_REF;
          3'b010:  dec_code = ap_bit ? CMD_PREA : CMD_PRE;
          3'b011:  dec_code = CMD_RFU;
          3'b100:  dec_code = CMD_WR;
          3'b101:  dec_code = CMD_RD;
          3'b110:  dec_code = CMD_ZQC;
          default: dec_valid = 1'b0;
        endcase
      end
    end
  end

  assign is_act  = dec_valid && (dec_code == CMD_ACT);
  assign is_rdwr = dec_valid && ((dec_code == CMD_RD) || (dec_code == CMD_WR));
  assign is_pre  = dec_valid && (dec_code == CMD_PRE);
  assign is_prea = dec_valid && (dec_code == CMD_PREA);
  assign is_ref  = dec_valid && (dec_code == CMD_REF);
  assign is_rfu  = dec_valid && (dec_code == CMD_RFU);

  // Auto-precharge behaves like a PRE to the same bank; closing an already closed bank is a no-op.
  always_comb begin
    act_hit   = '0;
    close_hit = '0;
    for (int i = 0; i < 16; i++) begin
      act_hit[i]   = is_act && (bank_idx == 4'(i));
      close_hit[i] = bank_open[i] &&
                     (is_prea || ((is_pre || (is_rdwr && ap_bit)) && (bank_idx == 4'(i))));
    end
  end

  always_comb begin
    err_now = 3'd0;
    if (is_act && bank_open[bank_idx])              err_now = 3'd1;
    else if (is_rdwr && !bank_open[bank_idx])       err_now = 3'd2;
    else if (is_rdwr && trcd_cnt[bank_idx] != 4'd0) err_now = 3'd3;
    else if (is_act && trp_cnt[bank_idx] != 4'd0)   err_now = 3'd4;
    else if (is_ref && |bank_open)                  err_now = 3'd5;
    else if (is_rfu)                                err_now = 3'd6;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bank_open <= '0;
      for (int i = 0; i < 16; i++) begin
        open_row[i] <= '0;
        trcd_cnt[i] <= '0;
        trp_cnt[i]  <= '0;
      end
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      cmd_ap    <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_count <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (trcd_cnt[i] != 4'd0) trcd_cnt[i] <= trcd_cnt[i] - 4'd1;
        if (trp_cnt[i] != 4'd0)  trp_cnt[i]  <= trp_cnt[i] - 4'd1;
        if (act_hit[i]) begin
          bank_open[i] <= 1'b1;
          open_row[i]  <= act_row;
          trcd_cnt[i]  <= TRCD_ARM;
        end
        if (close_hit[i]) begin
          bank_open[i] <= 1'b0;
          trp_cnt[i]   <= TRP_ARM;
        end
      end
      cmd_valid <= dec_valid;
      cmd_code  <= dec_valid ? dec_code : 4'd0;
      cmd_bank  <= dec_valid ? bank_idx : 4'd0;
      cmd_row   <= is_act ? act_row : 18'd0;
      cmd_col   <= is_rdwr ? addr[9:0] : 10'd0;
      cmd_ap    <= is_rdwr && ap_bit;
      err_valid <= (err_now != 3'd0);
      err_code  <= err_now;
      if ((err_now != 3'd0) && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Directed bench for ddr4_cmd_decoder (TRCD=TRP=4); each issued command is checked
// #1 after the edge that registers it.
module tb_ddr4_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset_n, cs_n, cke, act_n, ras_n_a16, cas_n_a15, we_n_a14, addr_17;
  logic [1:0]  bg, ba;
  logic [13:0] addr;
  logic        cmd_valid, cmd_ap, err_valid;
  logic [3:0]  cmd_code, cmd_bank;
  logic [17:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] bank_open, err_count;
  logic [2:0]  err_code;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr4_cmd_decoder #(.TRCD(4), .TRP(4)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .cke(cke), .act_n(act_n),
    .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14), .addr_17(addr_17),
    .bg(bg), .ba(ba), .addr(addr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .cmd_ap(cmd_ap), .bank_open(bank_open),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic ck, input logic act, input logic [2:0] rcw,
                       input logic a17, input logic [3:0] bank, input logic [13:0] a);
    cs_n = cs; cke = ck; act_n = act;
    {ras_n_a16, cas_n_a15, we_n_a14} = rcw;
    addr_17 = a17; {bg, ba} = bank; addr = a;
    tick();
  endtask

  task automatic do_act(input logic [3:0] bank, input logic [17:0] row);
    drive(1'b0, 1'b1, 1'b0, row[16:14], row[17], bank, row[13:0]);
  endtask

  task automatic do_cmd(input logic [2:0] rcw, input logic [3:0] bank, input logic [13:0] a);
    drive(1'b0, 1'b1, 1'b1, rcw, 1'b0, bank, a);
  endtask

  task automatic do_rd(input logic [3:0] bank, input logic [9:0] col, input logic ap);
    do_cmd(3'b101, bank, {3'b000, ap, col});
  endtask

  task automatic do_wr(input logic [3:0] bank, input logic [9:0] col, input logic ap);
    do_cmd(3'b100, bank, {3'b000, ap, col});
  endtask

  task automatic do_des;
    drive(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 4'd0, 14'd0);
  endtask

  task automatic chk_err(input string tag, input logic v, input logic [2:0] code, input logic [15:0] cnt);
    chk({tag, "_err_valid"}, 32'(err_valid), 32'(v));
    chk({tag, "_err_code"}, 32'(err_code), 32'(code));
    chk({tag, "_err_count"}, 32'(err_count), 32'(cnt));
  endtask

  initial begin
    reset_n = 1'b0;
    cs_n = 1'b1; cke = 1'b1; act_n = 1'b1;
    {ras_n_a16, cas_n_a15, we_n_a14} = 3'b111;
    addr_17 = 1'b0; bg = '0; ba = '0; addr = '0;
    tick(); tick();
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_bank_open", 32'(bank_open), 0);
    chk_err("rst", 1'b0, 3'd0, 16'd0);
    reset_n = 1'b1;

    // ACT bank 5 then RD exactly TRCD cycles later
    do_act(4'd5, 18'h2ABCD);
    chk("act5_valid", 32'(cmd_valid), 1);
    chk("act5_code", 32'(cmd_code), 0);
    chk("act5_bank", 32'(cmd_bank), 5);
    chk("act5_row", 32'(cmd_row), 32'h2ABCD);
    chk("act5_col", 32'(cmd_col), 0);
    chk_err("act5", 1'b0, 3'd0, 16'd0);
    do_des();
    chk("des_valid", 32'(cmd_valid), 0);
    do_des(); do_des();
    do_rd(4'd5, 10'd10, 1'b0);
    chk("rd5_valid", 32'(cmd_valid), 1);
    chk("rd5_code", 32'(cmd_code), 1);
    chk("rd5_col", 32'(cmd_col), 10);
    chk("rd5_row", 32'(cmd_row), 0);
    chk("rd5_ap", 32'(cmd_ap), 0);
    chk("rd5_open", 32'(bank_open), 32'h0020);
    chk_err("rd5", 1'b0, 3'd0, 16'd0);

    // WR two cycles after ACT violates tRCD
    do_act(4'd3, 18'h00001);
    do_des();
    do_wr(4'd3, 10'd7, 1'b0);
    chk("wr3_code", 32'(cmd_code), 2);
    chk_err("wr3", 1'b1, 3'd3, 16'd1);
    chk("wr3_open", 32'(bank_open), 32'h0028);
    do_cmd(3'b010, 4'd0, 14'h0400);
    chk("prea1_code", 32'(cmd_code), 4);
    chk("prea1_open", 32'(bank_open), 0);
    chk_err("prea1", 1'b0, 3'd0, 16'd1);

    // PREA then ACT too early, then ACT on an untouched bank
    do_act(4'd0, 18'h00010);
    do_act(4'd9, 18'h00020);
    chk("act09_open", 32'(bank_open), 32'h0201);
    do_cmd(3'b010, 4'd0, 14'h0400);
    chk("prea2_open", 32'(bank_open), 0);
    do_des();
    do_act(4'd9, 18'h00030);
    chk_err("act9_trp", 1'b1, 3'd4, 16'd2);
    chk("act9_open", 32'(bank_open), 32'h0200);
    do_act(4'd1, 18'h00040);
    chk_err("act1", 1'b0, 3'd0, 16'd2);
    chk("act1_open", 32'(bank_open), 32'h0202);

    // WR with auto-precharge at k=TRCD closes bank 9 and arms tRP
    do_des(); do_des();
    do_wr(4'd9, 10'h3FF, 1'b1);
    chk("wrap_ap", 32'(cmd_ap), 1);
    chk("wrap_col", 32'(cmd_col), 32'h3FF);
    chk_err("wrap", 1'b0, 3'd0, 16'd2);
    chk("wrap_open", 32'(bank_open), 32'h0002);
    do_act(4'd9, 18'h00050);
    chk_err("act9_ap_trp", 1'b1, 3'd4, 16'd3);

    // PRE to a closed bank must not arm tRP
    do_cmd(3'b010, 4'd4, 14'h0000);
    chk("pre4_code", 32'(cmd_code), 3);
    chk_err("pre4", 1'b0, 3'd0, 16'd3);
    do_act(4'd4, 18'h00060);
    chk_err("act4", 1'b0, 3'd0, 16'd3);
    chk("act4_open", 32'(bank_open), 32'h0212);

    // REF with banks open, RD to a never-activated bank
    do_act(4'd2, 18'h00070);
    do_cmd(3'b001, 4'd0, 14'h0000);
    chk("ref_code", 32'(cmd_code), 5);
    chk_err("ref", 1'b1, 3'd5, 16'd4);
    chk("ref_open", 32'(bank_open), 32'h0216);
    do_rd(4'd7, 10'd1, 1'b0);
    chk_err("rd7", 1'b1, 3'd2, 16'd5);

    // RD one cycle short of TRCD, then at TRCD
    do_act(4'd12, 18'h3FFFF);
    chk("act12_row", 32'(cmd_row), 32'h3FFFF);
    do_des(); do_des();
    do_rd(4'd12, 10'd2, 1'b0);
    chk_err("rd12_early", 1'b1, 3'd3, 16'd6);
    do_rd(4'd12, 10'd3, 1'b0);
    chk_err("rd12_ok", 1'b0, 3'd0, 16'd6);

    // Other codes, NOP, DES with act_n low, CKE low
    do_cmd(3'b000, 4'd0, 14'd0);
    chk("mrs_code", 32'(cmd_code), 6);
    do_cmd(3'b110, 4'd0, 14'd0);
    chk("zqc_code", 32'(cmd_code), 7);
    do_cmd(3'b111, 4'd0, 14'd0);
    chk("nop_valid", 32'(cmd_valid), 0);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 4'd0, 14'd0);
    chk("des_act_valid", 32'(cmd_valid), 0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0, 14'd0);
    chk("cke0_valid", 32'(cmd_valid), 0);
    chk("cke0_open", 32'(bank_open), 32'h1216);
    chk_err("cke0", 1'b0, 3'd0, 16'd6);

    // Reset with banks open and an ACT on the pins
    reset_n = 1'b0;
    do_act(4'd3, 18'h00080);
    chk("rst2_valid", 32'(cmd_valid), 0);
    chk("rst2_code", 32'(cmd_code), 0);
    chk("rst2_bank", 32'(cmd_bank), 0);
    chk("rst2_row", 32'(cmd_row), 0);
    chk("rst2_open", 32'(bank_open), 0);
    chk_err("rst2", 1'b0, 3'd0, 16'd0);
    reset_n = 1'b1;
    do_act(4'd9, 18'h00090);
    chk_err("act9_after_rst", 1'b0, 3'd0, 16'd0);
    do_rd(4'd5, 10'd0, 1'b0);
    chk_err("rd5_after_rst", 1'b1, 3'd2, 16'd1);

    // err_count saturation over 65536 RFU commands
    reset_n = 1'b0;
    do_des();
    reset_n = 1'b1;
    for (int i = 0; i < 65535; i++) do_cmd(3'b011, 4'd0, 14'd0);
    chk("rfu_code", 32'(cmd_code), 8);
    chk_err("rfu_65535", 1'b1, 3'd6, 16'hFFFF);
    do_cmd(3'b011, 4'd0, 14'd0);
    chk_err("rfu_65536", 1'b1, 3'd6, 16'hFFFF);
    do_des();
    chk_err("rfu_hold", 1'b0, 3'd0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
